piso_serializer: RTL and testbench

Parallel-in serial-out serializer that sits directly upstream of the serial shift-register stages. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a serial output, with a bit-valid strobe and a last-bit marker. Back-to-back words stream with no idle cycle between them, so the downstream serial chain sees a continuous bit stream.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer.sv | 85 ++++++++
 tb/tb_piso_serializer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a given word width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: captures a word over valid/ready and emits it
// one bit per clock, reloading on the last-bit cycle so consecutive words stream gaplessly.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic             last_bit;
  logic             handshake;

  assign last_bit  = (state_q == SHIFT) && (cnt_q == CntMax);
  assign din_ready = !reset && ((state_q == IDLE) || last_bit);
  assign handshake = din_valid && din_ready;

  // Shift toward the output bit position, filling the vacated end with zero.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (handshake) begin
            sreg_d = din;
            cnt_d  = '0;
          end else begin
            sreg_d  = sreg_shifted;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend on registered state only.
  assign busy       = (state_q == SHIFT);
  assign sout_valid = busy;
  assign sout_last  = last_bit;
  assign sout       = busy && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked against a queue-of-pending-bits model plus a directed vector table.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;

  logic rdy_m, sout_m, sv_m, slast_m, busy_m;
  logic rdy_l, sout_l, sv_l, slast_l, busy_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (rdy_m),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .sout_last  (slast_m),
    .busy       (busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (rdy_l),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .sout_last  (slast_l),
    .busy       (busy_l)
  );

  // Model: bits still to be emitted, in emission order, per bit order.
  logic qm[$];
  logic ql[$];
  logic m_ready;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       sm;
    logic       sl;
    logic       sv;
    logic       last;
    logic       rdy;
    logic       bsy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the coming edge and compare outputs against the model.
  task automatic pre(input logic r, input logic v, input logic [7:0] d);
    logic e_sm, e_sl;
    reset     = r;
    din_valid = v;
    din       = d;
    #1;
    m_ready = !r && (qm.size() <= 1);
    e_sm = (qm.size() > 0) ? qm[0] : 1'b0;
    e_sl = (ql.size() > 0) ? ql[0] : 1'b0;
    chk("m_ready", rdy_m, m_ready);
    chk("m_sout", sout_m, e_sm);
    chk("m_valid", sv_m, qm.size() > 0);
    chk("m_last", slast_m, qm.size() == 1);
    chk("m_busy", busy_m, qm.size() > 0);
    chk("l_ready", rdy_l, m_ready);
    chk("l_sout", sout_l, e_sl);
    chk("l_valid", sv_l, ql.size() > 0);
    chk("l_last", slast_l, ql.size() == 1);
    chk("l_busy", busy_l, ql.size() > 0);
  endtask

  // Advance the model across the rising edge, then park at the falling edge.
  task automatic post();
    @(posedge clk);
    if (reset) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (din_valid && m_ready) begin
        for (int i = 7; i >= 0; i--) qm.push_back(din[i]);
        for (int i = 0; i < 8; i++) ql.push_back(din[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    pre(r, v, d);
    post();
  endtask

  initial begin
    // 8'hA5 single word; 8'hA5 is a bit palindrome so both orders emit 1,0,1,0,0,1,0,1.
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    din_valid = 1'b0;
    din       = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Still in reset with valid high: no capture, ready forced low.
    cycle(1'b1, 1'b1, 8'hFF);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 10; k++) begin
      pre(tbl[k].r, tbl[k].v, tbl[k].d);
      chk($sformatf("tbl%0d_sout_m", k), sout_m, tbl[k].sm);
      chk($sformatf("tbl%0d_sout_l", k), sout_l, tbl[k].sl);
      chk($sformatf("tbl%0d_valid", k), sv_m, tbl[k].sv);
      chk($sformatf("tbl%0d_last", k), slast_m, tbl[k].last);
      chk($sformatf("tbl%0d_ready", k), rdy_m, tbl[k].rdy);
      chk($sformatf("tbl%0d_busy", k), busy_l, tbl[k].bsy);
      post();
    end

    // LSB-first distinguishing word.
    cycle(1'b0, 1'b1, 8'h01);
    repeat (9) cycle(1'b0, 1'b0, 8'h00);

    // Back-to-back: sout_valid must stay high for all 16 bits.
    cycle(1'b0, 1'b1, 8'hA5);
    for (int k = 1; k <= 16; k++) begin
      pre(1'b0, k <= 8, 8'h3C);
      chk($sformatf("b2b_valid%0d", k), sv_m, 1'b1);
      chk($sformatf("b2b_ready%0d", k), rdy_m, (k == 8) || (k == 16));
      post();
    end
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    // Backpressure: din churns while not ready, 8'hFF presented on the last-bit cycle.
    cycle(1'b0, 1'b1, 8'h00);
    for (int k = 1; k < 8; k++) cycle(1'b0, 1'b1, 8'($urandom));
    cycle(1'b0, 1'b1, 8'hFF);
    repeat (9) cycle(1'b0, 1'b0, 8'h00);

    // Reset mid-word, then a fresh word.
    cycle(1'b0, 1'b1, 8'hA5);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    pre(1'b0, 1'b1, 8'h81);
    chk("rst_mid_busy", busy_m, 1'b0);
    chk("rst_mid_valid", sv_m, 1'b0);
    post();
    repeat (9) cycle(1'b0, 1'b0, 8'h00);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    repeat (10) cycle(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
